// File: rtl/logic_result_fifo_if.sv
// Valid/ready bundle linking the logic unit, the result FIFO and the writeback consumer.
// The slave side belongs to the FIFO; the master side belongs to its environment.
interface logic_result_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ONES_WIDTH = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_result;
    logic [2:0]            in_op;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic [2:0]            out_op;
    logic                  out_zero;
    logic                  out_parity;
    logic [ONES_WIDTH-1:0] out_ones;

    modport master (
        output in_valid, in_result, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_zero, out_parity, out_ones
    );

    modport slave (
        input  in_valid, in_result, in_op, out_ready,
        output in_ready, out_valid, out_result, out_op, out_zero, out_parity, out_ones
    );
endinterface

// File: rtl/logic_result_fifo.sv
// Result buffer behind the bitwise logic unit: tags each result with status flags,
// drops opcode 3'b111 entries (counting them) and presents a first-word-fall-through head.
module logic_result_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int ONES_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    logic_result_fifo_if.slave  bus,
    output logic [ADDR_WIDTH:0] count,
    output logic [7:0]          illegal_cnt
);
    localparam logic [2:0]          OP_ILLEGAL = 3'b111;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    function automatic logic [ONES_WIDTH-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
        logic [ONES_WIDTH-1:0] sum;
        sum = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            sum = sum + ONES_WIDTH'(v[i]);
        end
        return sum;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [DATA_WIDTH-1:0] result_mem [DEPTH];
    logic [2:0]            op_mem     [DEPTH];
    logic                  zero_mem   [DEPTH];
    logic                  parity_mem [DEPTH];
    logic [ONES_WIDTH-1:0] ones_mem   [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic                  ready;
    logic                  head_valid;
    logic                  accept;
    logic                  push;
    logic                  discard;
    logic                  pop;

    logic                  zero_p0;
    logic                  parity_p0;
    logic [ONES_WIDTH-1:0] ones_p0;

    assign ready      = (count != FULL_COUNT) && !clear;
    assign head_valid = (count != '0);
    assign accept     = bus.in_valid && ready;
    assign push       = accept && (bus.in_op != OP_ILLEGAL);
    assign discard    = accept && (bus.in_op == OP_ILLEGAL);
    assign pop        = head_valid && bus.out_ready;

    // Stage p0: flags derived from the incoming result at push time
    assign zero_p0   = (bus.in_result == '0);
    assign parity_p0 = ^bus.in_result;
    assign ones_p0   = popcount(bus.in_result);

    always_ff @(posedge clk) begin
        if (push) begin
            result_mem[wr_ptr] <= bus.in_result;
            op_mem[wr_ptr]     <= bus.in_op;
            zero_mem[wr_ptr]   <= zero_p0;
            parity_mem[wr_ptr] <= parity_p0;
            ones_mem[wr_ptr]   <= ones_p0;
        end
    end

    // clear outranks push/pop but leaves the discard counter alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            illegal_cnt <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (push && !pop) begin
                count <= count + (ADDR_WIDTH + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (ADDR_WIDTH + 1)'(1);
            end
            if (discard) begin
                illegal_cnt <= sat_inc8(illegal_cnt);
            end
        end
    end

    // Head view: zeros whenever empty so reset and flush leave a clean output
    assign bus.in_ready   = ready;
    assign bus.out_valid  = head_valid;
    assign bus.out_result = head_valid ? result_mem[rd_ptr] : '0;
    assign bus.out_op     = head_valid ? op_mem[rd_ptr]     : 3'b000;
    assign bus.out_zero   = head_valid ? zero_mem[rd_ptr]   : 1'b0;
    assign bus.out_parity = head_valid ? parity_mem[rd_ptr] : 1'b0;
    assign bus.out_ones   = head_valid ? ones_mem[rd_ptr]   : '0;
endmodule

// File: tb/tb_logic_result_fifo.sv
// Directed plus random bench for logic_result_fifo, checked every cycle against a queue model.
module tb_logic_result_fifo;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] result;
        logic [2:0] op;
    } ent_t;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [2:0] count;
    logic [7:0] illegal_cnt;

    int   n_vec;
    int   n_err;
    ent_t q[$];
    int   ill;

    logic_result_fifo_if #(.DATA_WIDTH(8), .ONES_WIDTH(4)) bus ();

    logic_result_fifo #(
        .DATA_WIDTH(8),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(2),
        .ONES_WIDTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .bus        (bus),
        .count      (count),
        .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow directly from the queue contents
    task automatic check_outputs(input bit clr_now);
        bit         v;
        logic [7:0] r;
        logic [2:0] o;
        v = (q.size() != 0);
        r = v ? q[0].result : 8'h00;
        o = v ? q[0].op : 3'd0;
        chk("in_ready", 32'(bus.in_ready), 32'((q.size() != DEPTH) && !clr_now));
        chk("out_valid", 32'(bus.out_valid), 32'(v));
        chk("out_result", 32'(bus.out_result), 32'(r));
        chk("out_op", 32'(bus.out_op), 32'(o));
        chk("out_zero", 32'(bus.out_zero), 32'(v && (r == 8'h00)));
        chk("out_parity", 32'(bus.out_parity), 32'(v && ($countones(r) % 2 == 1)));
        chk("out_ones", 32'(bus.out_ones), v ? 32'($countones(r)) : 32'd0);
        chk("count", 32'(count), 32'(q.size()));
        chk("illegal_cnt", 32'(illegal_cnt), 32'(ill));
    endtask

    task automatic model_update(input bit v, input logic [7:0] r, input logic [2:0] o,
                                input bit ordy, input bit clr);
        bit   rdy;
        ent_t e;
        rdy = (q.size() != DEPTH) && !clr;
        if (clr) begin
            q.delete();
        end else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (v && rdy) begin
                if (o == 3'd7) begin
                    if (ill < 255) ill++;
                end else begin
                    e.result = r;
                    e.op     = o;
                    q.push_back(e);
                end
            end
        end
    endtask

    // Entered at posedge+1; drives, checks at the falling edge, advances one clock
    task automatic step(input bit v, input logic [7:0] r, input logic [2:0] o,
                        input bit ordy, input bit clr);
        bus.in_valid  = v;
        bus.in_result = r;
        bus.in_op     = o;
        bus.out_ready = ordy;
        clear         = clr;
        @(negedge clk);
        check_outputs(clr);
        model_update(v, r, o, ordy, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() != 0; i++) step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ill   = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_result = 8'h00;
        bus.in_op     = 3'd0;
        bus.out_ready = 1'b0;
        #1;
        check_outputs(1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single push then idle
        step(1'b1, 8'h88, 3'd0, 1'b0, 1'b0);
        chk("tp1_result", 32'(bus.out_result), 32'h88);
        chk("tp1_ones", 32'(bus.out_ones), 32'd2);
        chk("tp1_parity", 32'(bus.out_parity), 32'd0);
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        drain();

        // Fill to full, refuse a fifth, then pop reopens the input
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 3'($urandom_range(0, 6)), 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        step(1'b1, 8'h11, 3'd0, 1'b0, 1'b0);
        chk("full_hold", 32'(count), 32'd4);
        step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        chk("reopen_ready", 32'(bus.in_ready), 32'd1);
        step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);

        // Simultaneous push and pop at count 2, then mixed traffic across the wrap
        step(1'b1, 8'hFF, 3'd1, 1'b1, 1'b0);
        chk("pushpop_count", 32'(count), 32'd2);
        for (int i = 0; i < 10; i++)
            step(1'($urandom), 8'($urandom), 3'($urandom_range(0, 6)), 1'($urandom), 1'b0);
        drain();

        // Illegal opcode discards and counter saturation
        for (int i = 0; i < 3; i++) step(1'b1, 8'h55, 3'd7, 1'b0, 1'b0);
        chk("ill_three", 32'(illegal_cnt), 32'd3);
        chk("ill_count", 32'(count), 32'd0);
        for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 3'd7, 1'($urandom), 1'b0);
        chk("ill_sat", 32'(illegal_cnt), 32'd255);

        // Flush with count 3 while push and pop are requested
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 3'($urandom_range(0, 6)), 1'b0, 1'b0);
        chk("pre_clear_count", 32'(count), 32'd3);
        step(1'b1, 8'hAA, 3'd2, 1'b1, 1'b1);
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_valid", 32'(bus.out_valid), 32'd0);
        chk("clear_ill", 32'(illegal_cnt), 32'd255);

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            logic [2:0] o;
            o = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            step(1'($urandom), 8'($urandom), o, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 31) == 0));
        end
        drain();

        // Asynchronous reset with two entries stored
        step(1'b1, 8'h00, 3'd6, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 3'd2, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd2);
        #2;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ill", 32'(illegal_cnt), 32'd0);
        q.delete();
        ill = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'h00, 3'd3, 1'b0, 1'b0);
        chk("zero_flag", 32'(bus.out_zero), 32'd1);
        chk("zero_parity", 32'(bus.out_parity), 32'd0);
        chk("zero_ones", 32'(bus.out_ones), 32'd0);
        step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
